// File: rtl/mic_pkg.sv
// -----------------------------------------------------------------------------
// mic_pkg
// Shared definitions for the microphone frame path. The frame collector and the
// downstream adder-tree wrapper both use these.
//   NUM_CH   : microphone channels per frame
//   DATA_W   : sample width in bits (two's complement)
//   sample_t : one channel sample
//   frame_t  : one complete frame, element k is channel k
// -----------------------------------------------------------------------------
package mic_pkg;

    localparam int NUM_CH = 16;
    localparam int DATA_W = 23;

    typedef logic [DATA_W-1:0] sample_t;
    typedef sample_t           frame_t [NUM_CH];

endpackage : mic_pkg

// File: rtl/mic_frame_collector.sv
// -----------------------------------------------------------------------------
// mic_frame_collector
// Collects a serial stream of channel samples into complete frames. Frames are
// handed to the adder tree as one parallel array. Two frame banks are used as a
// ping-pong pair, so one frame can fill while the other frame waits to be taken.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   s_valid     : serial sample valid
//   s_ready     : a sample can be accepted (the write bank is not full)
//   s_data      : channel sample, two's complement, stored unmodified
//   s_first     : marks the beat as channel 0 of a frame
//   m_valid     : a complete frame is presented on m_data
//   m_ready     : the adder tree takes the frame
//   m_data      : presented frame, element k is channel k
//   sync_err    : one-cycle pulse when a partial frame is discarded
//   frame_cnt   : count of frames handed off, wraps at 16 bits
// -----------------------------------------------------------------------------
module mic_frame_collector #(
    parameter int NUM_CH = mic_pkg::NUM_CH,
    parameter int DATA_W = mic_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_first,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data [NUM_CH-1:0],
    output logic              sync_err,
    output logic [15:0]       frame_cnt
);

    localparam int              CNT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

    logic [DATA_W-1:0] bank [2][NUM_CH];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_sel;
    logic              rd_sel;
    logic [CNT_W-1:0]  ch_cnt;

    logic              accept;
    logic              consume;
    logic              last_beat;
    logic [CNT_W-1:0]  wr_ch;

    // Completion and consumption can never target the same bank: the write
    // bank is accepting, so it is not full, and the read bank is full.
    assign s_ready   = !full[wr_sel];
    assign m_valid   = full[rd_sel];
    assign accept    = s_valid && s_ready;
    assign consume   = m_valid && m_ready;

    // An s_first beat always lands in channel 0. Any partial frame already in
    // the write bank is overwritten from the start.
    assign wr_ch     = s_first ? '0 : ch_cnt;
    assign last_beat = accept && (wr_ch == LAST_CH);

    always_comb begin
        // NOTE: assign a default first so that every path drives full_nxt and
        // no latch is inferred.
        full_nxt = full;
        if (last_beat) full_nxt[wr_sel] = 1'b1;
        if (consume)   full_nxt[rd_sel] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            ch_cnt    <= '0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
        end else begin
            full     <= full_nxt;
            sync_err <= accept && s_first && (ch_cnt != '0);

            if (accept) begin
                if (wr_ch == LAST_CH) begin
                    ch_cnt <= '0;
                    wr_sel <= !wr_sel;
                end else begin
                    ch_cnt <= wr_ch + CNT_W'(1);
                end
            end

            if (consume) begin
                rd_sel    <= !rd_sel;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // NOTE: the bank storage has no reset. The full flags alone define what
    // is valid, and the data is don't-care until a frame completes.
    always_ff @(posedge clk) begin
        if (accept) bank[wr_sel][wr_ch] <= s_data;
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) m_data[k] = bank[rd_sel][k];
    end

endmodule : mic_frame_collector

// File: tb/tb_mic_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_mic_frame_collector
// Directed test of mic_frame_collector with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mic_frame_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [22:0] s_data;
    logic        s_first;
    logic        m_valid;
    logic        m_ready;
    logic [22:0] m_data [15:0];
    logic        sync_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int beat_idx;

    mic_frame_collector #(.NUM_CH(16), .DATA_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_first   (s_first),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .sync_err  (sync_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] pat(input int i);
        return 23'(i * 4099 + 'h1234);
    endfunction

    // Offer one beat and wait, with a bound, until it is accepted.
    // Returns #1 after the accepting edge with s_valid low.
    task automatic send(input logic [22:0] d, input logic first);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_first = first;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout observed=s_ready_low required=s_ready_high");
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    // One clock of the continuous stream: counts the beat if it was accepted,
    // then presents the next pattern sample.
    task automatic cycle();
        bit acc;
        acc = s_valid && s_ready;
        @(posedge clk); #1;
        if (acc) beat_idx++;
        s_data  = pat(beat_idx);
        s_first = (beat_idx % 16 == 0);
    endtask

    initial begin
        int sum;
        int stalls;
        int n;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_first = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame: channel k carries k*0x1000
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("basic_no_early_valid", 32'(m_valid), 32'd0);
            send(23'(k * 'h1000), k == 0);
        end
        check("basic_m_valid", 32'(m_valid), 32'd1);
        check("basic_d0", 32'(m_data[0]), 32'h0);
        check("basic_d1", 32'(m_data[1]), 32'h1000);
        check("basic_d9", 32'(m_data[9]), 32'h9000);
        check("basic_d15", 32'(m_data[15]), 32'hF000);
        @(posedge clk); #1;
        check("basic_valid_one_cycle", 32'(m_valid), 32'd0);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);

        // Backpressure: 48 continuous beats with the consumer stalled
        m_ready  = 1'b0;
        beat_idx = 0;
        s_valid  = 1'b1;
        s_data   = pat(0);
        s_first  = 1'b1;
        repeat (32) cycle();
        check("bp_ready_low", 32'(s_ready), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_f0_d0", 32'(m_data[0]), 32'(pat(0)));
        check("bp_f0_d15", 32'(m_data[15]), 32'(pat(15)));
        repeat (3) cycle();
        check("bp_ready_stays_low", 32'(s_ready), 32'd0);
        check("bp_f0_stable", 32'(m_data[5]), 32'(pat(5)));
        m_ready = 1'b1;
        cycle();
        check("bp_f1_valid", 32'(m_valid), 32'd1);
        check("bp_f1_d0", 32'(m_data[0]), 32'(pat(16)));
        check("bp_f1_d15", 32'(m_data[15]), 32'(pat(31)));
        check("bp_cnt_after_f0", 32'(frame_cnt), 32'd2);
        check("bp_ready_back", 32'(s_ready), 32'd1);
        cycle();
        check("bp_cnt_after_f1", 32'(frame_cnt), 32'd3);
        check("bp_empty", 32'(m_valid), 32'd0);
        repeat (15) cycle();
        check("bp_f2_valid", 32'(m_valid), 32'd1);
        check("bp_f2_d0", 32'(m_data[0]), 32'(pat(32)));
        check("bp_f2_d15", 32'(m_data[15]), 32'(pat(47)));
        s_valid = 1'b0;
        cycle();
        check("bp_cnt_after_f2", 32'(frame_cnt), 32'd4);

        // Resync: s_first arrives at beat 5 of a frame
        for (int k = 0; k < 5; k++) send(23'('h300 + k), k == 0);
        check("rs_no_err_before", 32'(sync_err), 32'd0);
        send(23'h7AB, 1'b1);
        check("rs_sync_err_pulse", 32'(sync_err), 32'd1);
        send(23'h501, 1'b0);
        check("rs_sync_err_one_cycle", 32'(sync_err), 32'd0);
        for (int k = 2; k < 16; k++) send(23'('h500 + k), 1'b0);
        check("rs_m_valid", 32'(m_valid), 32'd1);
        check("rs_d0", 32'(m_data[0]), 32'h7AB);
        check("rs_d1", 32'(m_data[1]), 32'h501);
        check("rs_d15", 32'(m_data[15]), 32'h50F);
        check("rs_cnt_partial_not_counted", 32'(frame_cnt), 32'd4);
        @(posedge clk); #1;
        check("rs_cnt", 32'(frame_cnt), 32'd5);

        // Extremes, sent with s_first=0 on channel 0
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send((k % 2 == 0) ? 23'h3FFFFF : 23'h400000, 1'b0);
        check("ext_m_valid", 32'(m_valid), 32'd1);
        sum = 0;
        for (int k = 0; k < 16; k++) begin
            check("ext_bits", 32'(m_data[k]), (k % 2 == 0) ? 32'h3FFFFF : 32'h400000);
            sum += int'($signed(m_data[k]));
        end
        check("ext_sum", 32'(sum), 32'(8 * 4194303 - 8 * 4194304));
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("ext_cnt", 32'(frame_cnt), 32'd6);

        // Streaming: 1000 back-to-back frames after a fresh reset
        rst_n = 1'b0;
        #1;
        check("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        beat_idx = 0;
        stalls   = 0;
        n        = 0;
        s_valid  = 1'b1;
        s_data   = pat(0);
        s_first  = 1'b1;
        while (beat_idx < 16000 && n < 17000) begin
            if (!s_ready) stalls++;
            cycle();
            n++;
        end
        s_valid = 1'b0;
        cycle();
        check("stream_beats", 32'(beat_idx), 32'd16000);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_frame_cnt", 32'(frame_cnt), 32'd1000);

        // Reset after beat 7 with a frame held in the other bank
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(23'('h40 + k), k == 0);
        for (int k = 0; k < 7; k++) send(23'('h60 + k), k == 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstm_m_valid", 32'(m_valid), 32'd0);
        check("rstm_s_ready", 32'(s_ready), 32'd1);
        check("rstm_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(23'('h100 + k), k == 0);
        check("rstm_valid", 32'(m_valid), 32'd1);
        check("rstm_d0", 32'(m_data[0]), 32'h100);
        check("rstm_d7", 32'(m_data[7]), 32'h107);
        check("rstm_d15", 32'(m_data[15]), 32'h10F);
        @(posedge clk); #1;
        check("rstm_cnt", 32'(frame_cnt), 32'd1);
        check("rstm_drained", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mic_frame_collector

// File: doc/mic_frame_collector.md
MIC_FRAME_COLLECTOR -- requirements
Module: mic_frame_collector

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 16, giving the number of microphone channels per frame.
REQ-002 The block SHALL have parameter DATA_W, default 23, giving the sample width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: serial sample valid.
REQ-006 The block SHALL have port s_ready, output, 1 bit: the block can accept a sample.
REQ-007 The block SHALL have port s_data, input, DATA_W bits: channel sample, two's complement.
REQ-008 The block SHALL have port s_first, input, 1 bit: marks the beat as channel 0 of a frame.
REQ-009 The block SHALL have port m_valid, output, 1 bit: a complete frame is presented.
REQ-010 The block SHALL have port m_ready, input, 1 bit: the adder tree consumes the frame.
REQ-011 The block SHALL have port m_data, output, an unpacked array [NUM_CH-1:0] of DATA_W bits: element k is channel k, and it drives the 16x23 adder tree input directly.
REQ-012 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse when a partial frame is discarded.
REQ-013 The block SHALL have port frame_cnt, output, 16 bits: count of frames handed off, wrapping.

Function
REQ-014 A serial beat SHALL be accepted on a rising edge when s_valid and s_ready are both high.
REQ-015 Two frame banks (ping-pong) SHALL be kept, each with a full flag, plus a write-bank select wr_sel, a read-bank select rd_sel, and a channel counter ch_cnt (0..NUM_CH-1).
REQ-016 An accepted beat SHALL be written to bank[wr_sel][ch_cnt], and ch_cnt SHALL then increment.
REQ-017 When the beat at ch_cnt = NUM_CH-1 is accepted, the block SHALL set full[wr_sel], toggle wr_sel and wrap ch_cnt to 0.
REQ-018 s_ready SHALL equal !full[wr_sel], so at most two frames are held.
REQ-019 m_valid SHALL equal full[rd_sel], and m_data SHALL equal bank[rd_sel].
REQ-020 On m_valid && m_ready, the block SHALL clear full[rd_sel], toggle rd_sel and increment frame_cnt, wrapping from 0xFFFF to 0.
REQ-021 Latency: m_valid SHALL rise on the cycle after the last channel's beat is accepted, provided the bank it fills was the read bank.
REQ-022 m_data SHALL stay stable while m_valid is high and m_ready is low; a full bank is never written.
REQ-023 Throughput: one sample per cycle SHALL be sustained with no s_ready bubble whenever the consumer takes each frame within NUM_CH cycles.
REQ-024 A frame completion and a frame consumption in the same cycle SHALL both take effect (they act on different banks).
REQ-025 An accepted beat with s_first=1 SHALL be written to channel 0, and ch_cnt SHALL become 1.
REQ-026 If ch_cnt != 0 when an s_first beat is accepted, the block SHALL discard the partial frame, pulse sync_err for one cycle and leave frame_cnt unchanged.
REQ-027 An s_first beat while ch_cnt = 0 SHALL be normal, with no error.
REQ-028 A beat with s_first=0 while ch_cnt = 0 SHALL be accepted as channel 0, with no error.
REQ-029 Samples SHALL be stored unmodified: no sign extension, saturation or reordering.

Reset
REQ-030 On rst_n low, asynchronously: full=2'b00, wr_sel=0, rd_sel=0, ch_cnt=0, frame_cnt=0, sync_err=0.
REQ-031 During and after reset, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-032 Bank contents SHALL need no reset, and m_data is don't-care while m_valid=0.
REQ-033 Reset mid-frame or mid-handoff SHALL drop all held and partial frames, and the first beat after release is channel 0.

Structure
REQ-034 NUM_CH, DATA_W and the frame array typedef SHALL live in a shared package mic_pkg, also used by the adder tree wrapper.
REQ-035 The block SHALL be a single module with no sub-module; the bank storage is inline registers.
REQ-036 The implementation SHALL be 120-250 lines of RTL.

Verification
REQ-037 Basic frame: 16 beats of data k*0x1000 for k=0..15, first beat s_first=1, m_ready=1 -> m_valid for 1 cycle on the cycle after beat 15; m_data[k]=k*0x1000; frame_cnt=1.
REQ-038 Backpressure: m_ready=0, 48 continuous beats -> s_ready falls after beat 32; m_data holds frame 0; raising m_ready gives frames 0 then 1 in order; the third frame is then accepted.
REQ-039 Resync: s_first at beat 5 of a frame -> sync_err pulses once; the next 16 beats form a frame whose m_data[0] equals the s_first beat's data; frame_cnt counts only complete frames.
REQ-040 Extremes: samples 23'h3FFFFF and 23'h400000 alternating -> m_data bit-exact; the adder tree sum matches the reference model.
REQ-041 Streaming: 1000 back-to-back frames with m_ready=1 -> s_ready is never low; frame_cnt=1000.
REQ-042 Reset mid-frame: rst_n low after beat 7 -> m_valid=0, s_ready=1; the next 16 beats produce one correct frame.
